io_bus_ctrl: RTL and testbench

Memory-mapped I/O bus controller between the CPU data port and the peripheral set (digits, keyboard, leds, switches, beep). Accepts one CPU access at a time through a req/ready handshake. Decodes the address and drives a one-cycle enable to exactly one peripheral. Returns registered read data after a configurable number of wait cycles, and flags unmapped addresses as bus errors.

---
 rtl/io_bus_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped bridge from the CPU data port to digits/keyboard/leds/switches/beep.
// Latency: mapped access ready WAIT_CYCLES+1 cycles after accept; unmapped/internal ready 1 cycle after.
// Backpressure: one access in flight, cpu_req sampled only in IDLE. `IO_ERR_STATUS_EN adds fault reg at 0xFFFFFCFx.
module io_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_sel,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_byte_sel,
  output logic        per_we,
  output logic [4:0]  per_en,
  input  logic [31:0] rdata_digits,
  input  logic [31:0] rdata_kbd,
  input  logic [31:0] rdata_leds,
  input  logic [31:0] rdata_sw,
  input  logic [31:0] rdata_beep
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int unsigned WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD = WAIT_M1[3:0];
  localparam logic        WAIT_NONE = (WAIT_CYCLES == 0);

  logic [1:0]  r_state;
  logic [3:0]  r_wait_cnt;
  logic [4:0]  r_sel;
  logic [4:0]  r_per_en;
  logic        r_cpu_ready;
  logic        r_cpu_err;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_per_addr;
  logic [31:0] r_per_wdata;
  logic [3:0]  r_per_byte_sel;
  logic        r_per_we;

  logic [4:0]  w_sel;
  logic [31:0] w_rd_mux;
  logic [31:0] w_capture;
  logic        w_stat_hit;
  logic [31:0] w_stat_rdata;

  // Decode the incoming address into a one-hot peripheral select (0 = not a peripheral)
  always_comb begin
    w_sel = 5'b00000;
    case (cpu_addr[31:4])
      28'hFFFFFC0: w_sel = 5'b00001;
      28'hFFFFFC1: w_sel = 5'b00010;
      28'hFFFFFC6: w_sel = 5'b00100;
      28'hFFFFFC7: w_sel = 5'b01000;
      28'hFFFFFD1: w_sel = 5'b10000;
      default:     w_sel = 5'b00000;
    endcase
  end

  // Steer the selected peripheral's data_out using the select latched at accept
  always_comb begin
    w_rd_mux = 32'h0;
    case (r_sel)
      5'b00001: w_rd_mux = rdata_digits;
      5'b00010: w_rd_mux = rdata_kbd;
      5'b00100: w_rd_mux = rdata_leds;
      5'b01000: w_rd_mux = rdata_sw;
      5'b10000: w_rd_mux = rdata_beep;
      default:  w_rd_mux = 32'h0;
    endcase
  end

  // Writes complete with zero read data
  assign w_capture = r_per_we ? 32'h0 : w_rd_mux;

`ifdef IO_ERR_STATUS_EN
  logic [31:0] r_fault;
  logic        r_stat_rd;

  assign w_stat_hit   = (cpu_addr[31:4] == 28'hFFFFFCF);
  assign w_stat_rdata = r_fault;

  // Record the last unmapped address; a read of the register clears it as the response retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault   <= 32'h0;
      r_stat_rd <= 1'b0;
    end else if (r_state == ST_IDLE && cpu_req) begin
      if (w_sel == 5'b00000 && !w_stat_hit) begin
        r_fault <= cpu_addr;
      end
      r_stat_rd <= (w_sel == 5'b00000) && w_stat_hit && !cpu_we;
    end else if (r_state == ST_RESP && r_stat_rd) begin
      r_fault   <= 32'h0;
      r_stat_rd <= 1'b0;
    end
  end
`else
  assign w_stat_hit   = 1'b0;
  assign w_stat_rdata = 32'h0;
`endif

  // Access sequencer: accept, strobe the enable, wait, capture, respond for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= 4'h0;
      r_sel          <= 5'b00000;
      r_per_en       <= 5'b00000;
      r_cpu_ready    <= 1'b0;
      r_cpu_err      <= 1'b0;
      r_cpu_rdata    <= 32'h0;
      r_per_addr     <= 32'h0;
      r_per_wdata    <= 32'h0;
      r_per_byte_sel <= 4'h0;
      r_per_we       <= 1'b0;
    end else begin
      r_per_en    <= 5'b00000;
      r_cpu_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_per_addr     <= cpu_addr;
            r_per_wdata    <= cpu_wdata;
            r_per_byte_sel <= cpu_byte_sel;
            r_per_we       <= cpu_we;
            r_sel          <= w_sel;
            if (w_sel != 5'b00000) begin
              r_per_en <= w_sel;
              r_state  <= ST_ACCESS;
            end else if (w_stat_hit) begin
              r_cpu_ready <= 1'b1;
              r_cpu_rdata <= cpu_we ? 32'h0 : w_stat_rdata;
              r_state     <= ST_RESP;
            end else begin
              r_cpu_ready <= 1'b1;
              r_cpu_err   <= 1'b1;
              r_cpu_rdata <= ERR_RDATA;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (WAIT_NONE) begin
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= w_capture;
            r_state     <= ST_RESP;
          end else begin
            r_wait_cnt <= WAIT_LOAD;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'h0) begin
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= w_capture;
            r_state     <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'h1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready    = r_cpu_ready;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_err      = r_cpu_err;
  assign per_addr     = r_per_addr;
  assign per_wdata    = r_per_wdata;
  assign per_byte_sel = r_per_byte_sel;
  assign per_we       = r_per_we;
  assign per_en       = r_per_en;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: three instances (WAIT_CYCLES 0, 1, 4) share the bus inputs but have
// private cpu_req lines; expectations come from an address-table model of the bridge.
`timescale 1ns/1ps
module tb_io_bus_ctrl;

  localparam logic [31:0] ERR_VAL = 32'hBAD0_0BAD;

  typedef struct {
    int          en_cycles;
    int          en_first;
    logic [4:0]  en_val;
    int          rdy_cyc;
    int          rdy_cnt;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pbsel;
    logic        pwe;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [3];
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  bsel = 4'h0;
  logic [31:0] pdata [5];

  logic        ready_o  [3];
  logic [31:0] rdata_o  [3];
  logic        err_o    [3];
  logic [31:0] paddr_o  [3];
  logic [31:0] pwdata_o [3];
  logic [3:0]  pbsel_o  [3];
  logic        pwe_o    [3];
  logic [4:0]  pen_o    [3];

  logic [31:0] model_fault [3];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    io_bus_ctrl #(
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 4),
      .ERR_RDATA(ERR_VAL)
    ) u_dut (
      .clk(clk), .rst(rst), .cpu_req(req[g]), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_byte_sel(bsel), .cpu_ready(ready_o[g]), .cpu_rdata(rdata_o[g]),
      .cpu_err(err_o[g]), .per_addr(paddr_o[g]), .per_wdata(pwdata_o[g]),
      .per_byte_sel(pbsel_o[g]), .per_we(pwe_o[g]), .per_en(pen_o[g]),
      .rdata_digits(pdata[0]), .rdata_kbd(pdata[1]), .rdata_leds(pdata[2]),
      .rdata_sw(pdata[3]), .rdata_beep(pdata[4])
    );
  end

  function automatic int wcyc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 4;
  endfunction

  function automatic logic [31:0] per_base(input int i);
    case (i)
      0:       return 32'hFFFF_FC00;
      1:       return 32'hFFFF_FC10;
      2:       return 32'hFFFF_FC60;
      3:       return 32'hFFFF_FC70;
      default: return 32'hFFFF_FD10;
    endcase
  endfunction

  // Peripheral index 0..4, 5 for the fault register, -1 for unmapped
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 5; i++) begin
      if ((a >> 4) == (per_base(i) >> 4)) return i;
    end
`ifdef IO_ERR_STATUS_EN
    if ((a >> 4) == 32'h0FFF_FFCF) return 5;
`endif
    return -1;
  endfunction

  // Expected observation of one isolated access, then advance the fault-register model
  task automatic model_access(input int k, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b, output obs_t e);
    int idx;
    idx = decode(a);
    e.en_cycles = (idx >= 0 && idx < 5) ? 1 : 0;
    e.en_first  = (idx >= 0 && idx < 5) ? 0 : -1;
    e.en_val    = (idx >= 0 && idx < 5) ? 5'(1 << idx) : 5'b0;
    e.rdy_cyc   = (idx >= 0 && idx < 5) ? wcyc(k) + 1 : 0;
    e.rdy_cnt   = 1;
    e.err       = (idx < 0);
    if (idx < 0)      e.rdata = ERR_VAL;
    else if (w)       e.rdata = 32'h0;
    else if (idx == 5) e.rdata = model_fault[k];
    else              e.rdata = pdata[idx];
    e.paddr = a; e.pwdata = d; e.pbsel = b; e.pwe = w;
    if (idx < 0) model_fault[k] = a;
    else if (idx == 5 && !w) model_fault[k] = 32'h0;
  endtask

  // Issue one request on instance k and record what the bus did, bounded to 41 cycles
  task automatic run_access(input int k, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, output obs_t o);
    int last;
    o.en_cycles = 0; o.en_first = -1; o.en_val = 5'b0; o.rdy_cyc = -1; o.rdy_cnt = 0;
    o.rdata = 32'h0; o.err = 1'b0; o.paddr = 32'h0; o.pwdata = 32'h0; o.pbsel = 4'h0; o.pwe = 1'b0;
    @(negedge clk);
    we = w; addr = a; wdata = d; bsel = b; req[k] = 1'b1;
    @(posedge clk);
    last = 40;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) begin
        o.paddr = paddr_o[k]; o.pwdata = pwdata_o[k]; o.pbsel = pbsel_o[k]; o.pwe = pwe_o[k];
      end
      if (pen_o[k] != 5'b0) begin
        o.en_cycles++;
        o.en_val = o.en_val | pen_o[k];
        if (o.en_first < 0) o.en_first = c;
      end
      if (ready_o[k]) begin
        o.rdy_cnt++;
        if (o.rdy_cyc < 0) begin
          o.rdy_cyc = c; o.rdata = rdata_o[k]; o.err = err_o[k];
          req[k] = 1'b0;
          last = c + 1;
        end
      end
    end
    req[k] = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({ready_o[k], err_o[k], pen_o[k], rdata_o[k]} !== 39'h0) begin
        n_errors++;
        $display("FAIL reset_resp k=%0d got rdy=%b err=%b en=%b rdata=%h exp all zero",
                 k, ready_o[k], err_o[k], pen_o[k], rdata_o[k]);
      end
      n_checks++;
      if ({paddr_o[k], pwdata_o[k], pbsel_o[k], pwe_o[k]} !== 69'h0) begin
        n_errors++;
        $display("FAIL reset_bus k=%0d got addr=%h wdata=%h bsel=%h we=%b exp all zero",
                 k, paddr_o[k], pwdata_o[k], pbsel_o[k], pwe_o[k]);
      end
      model_fault[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_write_leds;
    obs_t o;
    run_access(1, 1'b1, 32'hFFFF_FC60, 32'hAABB_CCDD, 4'hF, o);
    n_checks++;
    if (o.en_val !== 5'b00100 || o.en_cycles != 1 || o.en_first != 0) begin
      n_errors++;
      $display("FAIL wr_leds_en got %b x%0d @%0d exp 00100 x1 @0", o.en_val, o.en_cycles, o.en_first);
    end
    n_checks++;
    if (o.pwe !== 1'b1 || o.paddr !== 32'hFFFF_FC60 || o.pwdata !== 32'hAABB_CCDD) begin
      n_errors++;
      $display("FAIL wr_leds_bus got we=%b addr=%h wdata=%h exp 1 fffffc60 aabbccdd", o.pwe, o.paddr, o.pwdata);
    end
    n_checks++;
    if (o.rdy_cyc != 2 || o.rdy_cnt != 1) begin
      n_errors++;
      $display("FAIL wr_leds_ready got cyc=%0d cnt=%0d exp cyc=2 cnt=1", o.rdy_cyc, o.rdy_cnt);
    end
    n_checks++;
    if (o.err !== 1'b0 || o.rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL wr_leds_resp got err=%b rdata=%h exp 0 00000000", o.err, o.rdata);
    end
  endtask

  task automatic test_read_sw;
    obs_t o;
    pdata[3] = 32'h0012_3456;
    run_access(1, 1'b0, 32'hFFFF_FC70, 32'h0, 4'hF, o);
    n_checks++;
    if (o.en_val !== 5'b01000 || o.en_cycles != 1) begin
      n_errors++;
      $display("FAIL rd_sw_en got %b x%0d exp 01000 x1", o.en_val, o.en_cycles);
    end
    n_checks++;
    if (o.rdata !== 32'h0012_3456 || o.err !== 1'b0 || o.rdy_cyc != 2) begin
      n_errors++;
      $display("FAIL rd_sw_resp got rdata=%h err=%b cyc=%0d exp 00123456 0 2", o.rdata, o.err, o.rdy_cyc);
    end
  endtask

  task automatic test_latency;
    obs_t o;
    for (int k = 0; k < 3; k += 2) begin
      pdata[0] = $urandom;
      run_access(k, 1'b0, 32'hFFFF_FC00, 32'h0, 4'h3, o);
      n_checks++;
      if (o.rdy_cyc != wcyc(k) + 1 || o.rdata !== pdata[0] || o.en_val !== 5'b00001) begin
        n_errors++;
        $display("FAIL latency k=%0d got cyc=%0d rdata=%h en=%b exp cyc=%0d rdata=%h en=00001",
                 k, o.rdy_cyc, o.rdata, o.en_val, wcyc(k) + 1, pdata[0]);
      end
    end
  endtask

  task automatic test_unmapped;
    obs_t o, e;
    logic [31:0] seq_a [3];
    seq_a[0] = 32'h0000_1000; seq_a[1] = 32'hFFFF_FCF0; seq_a[2] = 32'hFFFF_FCF4;
    for (int i = 0; i < 3; i++) begin
      model_access(1, 1'b0, seq_a[i], 32'h0, 4'hF, e);
      run_access(1, 1'b0, seq_a[i], 32'h0, 4'hF, o);
      n_checks++;
      if (o.en_cycles != 0 || o.rdy_cyc != 0 || o.err !== e.err || o.rdata !== e.rdata) begin
        n_errors++;
        $display("FAIL unmapped_%0d got en=%0d cyc=%0d err=%b rdata=%h exp en=0 cyc=0 err=%b rdata=%h",
                 i, o.en_cycles, o.rdy_cyc, o.err, o.rdata, e.err, e.rdata);
      end
    end
    n_checks++;
    if (o.err !== 1'b1 && o.rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL status_clear got err=%b rdata=%h exp err=1 or rdata=0", o.err, o.rdata);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o, e;
    int rdy_seen;
    pdata[0] = $urandom | 32'h1;
    model_access(2, 1'b0, 32'hFFFF_FC04, 32'h0, 4'hF, e);
    run_access(2, 1'b0, 32'hFFFF_FC04, 32'h0, 4'hF, o);
    n_checks++;
    if (o.rdata !== e.rdata) begin
      n_errors++;
      $display("FAIL mid_prior_read got %h exp %h", o.rdata, e.rdata);
    end
    @(negedge clk);
    we = 1'b0; addr = 32'hFFFF_FD10; req[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (pen_o[2] !== 5'b10000) begin
      n_errors++;
      $display("FAIL mid_access_en got %b exp 10000", pen_o[2]);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (ready_o[2] !== 1'b0 || pen_o[2] !== 5'b0 || rdata_o[2] !== 32'h0 || paddr_o[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_reset_async got rdy=%b en=%b rdata=%h addr=%h exp all zero",
               ready_o[2], pen_o[2], rdata_o[2], paddr_o[2]);
    end
    req[2] = 1'b0;
    for (int k = 0; k < 3; k++) model_fault[k] = 32'h0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    rdy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready_o[2]) rdy_seen++;
    end
    n_checks++;
    if (rdy_seen != 0) begin
      n_errors++;
      $display("FAIL mid_no_ready got %0d ready cycles exp 0", rdy_seen);
    end
    run_access(2, 1'b1, 32'hFFFF_FD10, 32'h1234_5678, 4'h1, o);
    n_checks++;
    if (o.en_val !== 5'b10000 || o.en_cycles != 1 || o.rdy_cyc != 5 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_after_write got en=%b x%0d cyc=%0d err=%b rdata=%h exp 10000 x1 5 0 0",
               o.en_val, o.en_cycles, o.rdy_cyc, o.err, o.rdata);
    end
  endtask

  task automatic test_back_to_back;
    int p;
    logic [4:0] exp_en;
    logic exp_rdy;
    for (int k = 0; k < 3; k++) begin
      p = wcyc(k) + 3;
      @(negedge clk);
      we = 1'b0; addr = 32'hFFFF_FC68; req[k] = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3 * p; i++) begin
        @(negedge clk);
        exp_en  = (i % p == 0) ? 5'b00100 : 5'b00000;
        exp_rdy = (i % p == p - 2);
        if (i == 3 * p - 1) req[k] = 1'b0;
        n_checks++;
        if (pen_o[k] !== exp_en || ready_o[k] !== exp_rdy) begin
          n_errors++;
          $display("FAIL b2b k=%0d cyc=%0d got en=%b rdy=%b exp en=%b rdy=%b",
                   k, i, pen_o[k], ready_o[k], exp_en, exp_rdy);
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_random;
    obs_t o, e;
    int k, r, j;
    logic w;
    logic [31:0] a, d;
    logic [3:0] b;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 7);
      j = $urandom_range(0, 4);
      if (r <= 4)      a = per_base(j) | 32'($urandom_range(0, 15));
      else if (r == 5) a = 32'hFFFF_FCF0 | 32'($urandom_range(0, 15));
      else if (r == 6) a = $urandom;
      else             a = per_base(j) ^ (32'h1 << $urandom_range(4, 31));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      for (int q = 0; q < 5; q++) pdata[q] = $urandom;
      model_access(k, w, a, d, b, e);
      run_access(k, w, a, d, b, o);
      n_checks++;
      if (o.en_val !== e.en_val || o.en_cycles != e.en_cycles || o.en_first != e.en_first) begin
        n_errors++;
        $display("FAIL rnd_en #%0d a=%h got %b x%0d @%0d exp %b x%0d @%0d", i, a,
                 o.en_val, o.en_cycles, o.en_first, e.en_val, e.en_cycles, e.en_first);
      end
      n_checks++;
      if (o.rdy_cyc != e.rdy_cyc || o.rdy_cnt != e.rdy_cnt) begin
        n_errors++;
        $display("FAIL rnd_ready #%0d a=%h got cyc=%0d cnt=%0d exp cyc=%0d cnt=1", i, a,
                 o.rdy_cyc, o.rdy_cnt, e.rdy_cyc);
      end
      n_checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        n_errors++;
        $display("FAIL rnd_resp #%0d k=%0d a=%h we=%b got rdata=%h err=%b exp rdata=%h err=%b",
                 i, k, a, w, o.rdata, o.err, e.rdata, e.err);
      end
      n_checks++;
      if (o.paddr !== e.paddr || o.pwdata !== e.pwdata || o.pbsel !== e.pbsel || o.pwe !== e.pwe) begin
        n_errors++;
        $display("FAIL rnd_bus #%0d got %h %h %h %b exp %h %h %h %b", i,
                 o.paddr, o.pwdata, o.pbsel, o.pwe, e.paddr, e.pwdata, e.pbsel, e.pwe);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0;
      model_fault[k] = 32'h0;
    end
    for (int q = 0; q < 5; q++) pdata[q] = 32'h0;
    test_reset();
    test_write_leds();
    test_read_sw();
    test_latency();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
